// File: rtl/ring_step_sched_if.sv
// rtl/ring_step_sched_if.sv - requester/consumer signal bundle for ring_step_sched
interface ring_step_sched_if #(
  parameter int CNT_W = 4
);
  logic             req_a;
  logic             ud_a;
  logic [CNT_W-1:0] cnt_a;
  logic             req_b;
  logic             ud_b;
  logic [CNT_W-1:0] cnt_b;
  logic [2:0]       div;
  logic             home;
  logic             gnt_a;
  logic             gnt_b;
  logic             busy;
  logic             step;
  logic             ud;
  logic [3:0]       q;
  logic             done;
  logic             done_id;

  modport master (
    output req_a, ud_a, cnt_a, req_b, ud_b, cnt_b, div, home,
    input  gnt_a, gnt_b, busy, step, ud, q, done, done_id
  );

  modport slave (
    input  req_a, ud_a, cnt_a, req_b, ud_b, cnt_b, div, home,
    output gnt_a, gnt_b, busy, step, ud, q, done, done_id
  );
endinterface

// File: rtl/ring_step_sched.sv
// rtl/ring_step_sched.sv - round-robin scheduler sharing one one-hot ring stepper
// between two requesters, one step every P clocks.
module ring_step_sched #(
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               clear_n,
  ring_step_sched_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [2:0]       period;
  logic [2:0]       div_cnt;
  logic [CNT_W-1:0] remaining;
  logic             owner;
  logic             last_owner;

  logic             take_a;
  logic             take_b;
  logic             sel_ud;
  logic [CNT_W-1:0] sel_cnt;

  // On a tie the requester that was not served last wins.
  assign take_a  = bus.req_a && (!bus.req_b || last_owner);
  assign take_b  = bus.req_b && !take_a;
  assign sel_ud  = take_a ? bus.ud_a  : bus.ud_b;
  assign sel_cnt = take_a ? bus.cnt_a : bus.cnt_b;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state       <= IDLE;
      period      <= 3'd2;
      div_cnt     <= 3'd0;
      remaining   <= '0;
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      bus.q       <= 4'b0001;
      bus.ud      <= 1'b1;
      bus.gnt_a   <= 1'b0;
      bus.gnt_b   <= 1'b0;
      bus.step    <= 1'b0;
      bus.done    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done_id <= 1'b0;
    end else begin
      bus.gnt_a <= 1'b0;
      bus.gnt_b <= 1'b0;
      bus.step  <= 1'b0;
      bus.done  <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.home) begin
            bus.q <= 4'b0001;
          end
          if (take_a || take_b) begin
            owner      <= take_b;
            last_owner <= take_b;
            bus.ud     <= sel_ud;
            remaining  <= sel_cnt;
            period     <= (bus.div < 3'd2) ? 3'd2 : bus.div;
            div_cnt    <= 3'd0;
            bus.gnt_a  <= take_a;
            bus.gnt_b  <= take_b;
            bus.busy   <= 1'b1;
            if (sel_cnt == '0) begin
              state       <= DONE;
              bus.done    <= 1'b1;
              bus.done_id <= take_b;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          if (div_cnt == period - 3'd1) begin
            div_cnt   <= 3'd0;
            bus.step  <= 1'b1;
            remaining <= remaining - CNT_W'(1);
            bus.q     <= bus.ud ? {bus.q[2:0], bus.q[3]} : {bus.q[0], bus.q[3:1]};
            // The last step and the done pulse land in the same cycle.
            if (remaining == CNT_W'(1)) begin
              state       <= DONE;
              bus.done    <= 1'b1;
              bus.done_id <= owner;
            end
          end else begin
            div_cnt <= div_cnt + 3'd1;
          end
        end

        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_step_sched.sv
// tb/tb_ring_step_sched.sv - directed bench for ring_step_sched
module tb_ring_step_sched;

  logic clk;
  logic clear_n;
  int   npass;
  int   ntot;
  logic [3:0] qm;

  ring_step_sched_if #(.CNT_W(4)) bus ();

  ring_step_sched #(.CNT_W(4)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Follows one accepted command from the cycle after the grant through the
  // first IDLE cycle; qm holds the expected ring position.
  task automatic run_cmd(input string tag, input int n, input int p,
                         input logic up, input logic id, inout logic [3:0] qe);
    for (int k = 1; k <= n * p; k++) begin
      @(negedge clk);
      bus.home = 1'b0;
      if (k % p == 0) qe = up ? {qe[2:0], qe[3]} : {qe[0], qe[3:1]};
      chk({tag, " step"}, bus.step, (k % p == 0));
      chk({tag, " q"}, bus.q, qe);
      chk({tag, " busy"}, bus.busy, 1'b1);
      chk({tag, " done"}, bus.done, (k == n * p));
    end
    chk({tag, " done_id"}, bus.done_id, id);
    chk({tag, " ud"}, bus.ud, up);
    @(negedge clk);
    chk({tag, " idle busy"}, bus.busy, 1'b0);
    chk({tag, " idle done"}, bus.done, 1'b0);
    chk({tag, " idle step"}, bus.step, 1'b0);
  endtask

  initial begin
    npass = 0;
    ntot  = 0;
    clear_n   = 1'b0;
    bus.req_a = 1'b0; bus.ud_a = 1'b0; bus.cnt_a = 4'd0;
    bus.req_b = 1'b0; bus.ud_b = 1'b0; bus.cnt_b = 4'd0;
    bus.div   = 3'd2; bus.home = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst q", bus.q, 4'b0001);
    chk("rst ud", bus.ud, 1'b1);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst gnt_a", bus.gnt_a, 1'b0);
    chk("rst gnt_b", bus.gnt_b, 1'b0);
    chk("rst step", bus.step, 1'b0);
    chk("rst done", bus.done, 1'b0);
    chk("rst done_id", bus.done_id, 1'b0);

    // Single request: 3 steps up, P = 2
    clear_n = 1'b1;
    bus.req_a = 1'b1; bus.ud_a = 1'b1; bus.cnt_a = 4'd3; bus.div = 3'd2;
    @(negedge clk);
    chk("single gnt_a", bus.gnt_a, 1'b1);
    chk("single gnt_b", bus.gnt_b, 1'b0);
    chk("single busy0", bus.busy, 1'b1);
    bus.req_a = 1'b0;
    qm = 4'b0001;
    run_cmd("single", 3, 2, 1'b1, 1'b0, qm);
    chk("single final q", bus.q, 4'b1000);

    // Simultaneous requests after a fresh reset: A, then B, then A again
    clear_n = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    bus.req_a = 1'b1; bus.ud_a = 1'b1; bus.cnt_a = 4'd1;
    bus.req_b = 1'b1; bus.ud_b = 1'b0; bus.cnt_b = 4'd1;
    bus.div = 3'd3;
    @(negedge clk);
    chk("tie1 gnt_a", bus.gnt_a, 1'b1);
    chk("tie1 gnt_b", bus.gnt_b, 1'b0);
    bus.req_a = 1'b0;
    qm = 4'b0001;
    run_cmd("tie1", 1, 3, 1'b1, 1'b0, qm);
    @(negedge clk);
    chk("tie2 gnt_b", bus.gnt_b, 1'b1);
    chk("tie2 gnt_a", bus.gnt_a, 1'b0);
    bus.req_b = 1'b0;
    run_cmd("tie2", 1, 3, 1'b0, 1'b1, qm);
    chk("tie2 final q", bus.q, 4'b0001);
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    @(negedge clk);
    chk("tie3 gnt_a", bus.gnt_a, 1'b1);
    chk("tie3 gnt_b", bus.gnt_b, 1'b0);
    bus.req_a = 1'b0;
    run_cmd("tie3", 1, 3, 1'b1, 1'b0, qm);
    chk("tie3 final q", bus.q, 4'b0010);

    // Down wrap, div = 0 clamps to 2; home and accept in the same edge
    bus.home = 1'b1;
    bus.ud_b = 1'b0; bus.cnt_b = 4'd5; bus.div = 3'd0;
    @(negedge clk);
    chk("wrap gnt_b", bus.gnt_b, 1'b1);
    chk("wrap home q", bus.q, 4'b0001);
    bus.req_b = 1'b0; bus.home = 1'b0;
    qm = 4'b0001;
    run_cmd("wrap", 5, 2, 1'b0, 1'b1, qm);
    chk("wrap final q", bus.q, 4'b1000);

    // Zero count
    bus.req_a = 1'b1; bus.ud_a = 1'b1; bus.cnt_a = 4'd0; bus.div = 3'd2;
    @(negedge clk);
    chk("zero gnt_a", bus.gnt_a, 1'b1);
    chk("zero done", bus.done, 1'b1);
    chk("zero done_id", bus.done_id, 1'b0);
    chk("zero busy", bus.busy, 1'b1);
    chk("zero step", bus.step, 1'b0);
    chk("zero q", bus.q, 4'b1000);
    bus.req_a = 1'b0;
    @(negedge clk);
    chk("zero idle busy", bus.busy, 1'b0);
    chk("zero idle done", bus.done, 1'b0);
    chk("zero idle q", bus.q, 4'b1000);

    // Latched period 7 survives a div change and home during RUN
    bus.req_b = 1'b1; bus.ud_b = 1'b1; bus.cnt_b = 4'd2; bus.div = 3'd7;
    @(negedge clk);
    chk("latch gnt_b", bus.gnt_b, 1'b1);
    bus.req_b = 1'b0; bus.div = 3'd2; bus.home = 1'b1;
    qm = 4'b1000;
    run_cmd("latch", 2, 7, 1'b1, 1'b1, qm);
    chk("latch final q", bus.q, 4'b0010);

    // Home from 0100 in IDLE
    bus.req_a = 1'b1; bus.ud_a = 1'b1; bus.cnt_a = 4'd1;
    @(negedge clk);
    chk("pre-home gnt_a", bus.gnt_a, 1'b1);
    bus.req_a = 1'b0;
    run_cmd("pre-home", 1, 2, 1'b1, 1'b0, qm);
    chk("pre-home q", bus.q, 4'b0100);
    bus.home = 1'b1;
    @(negedge clk);
    chk("home q", bus.q, 4'b0001);
    chk("home busy", bus.busy, 1'b0);
    bus.home = 1'b0;

    // Reset mid-run aborts a 10-step command without a done pulse
    bus.req_a = 1'b1; bus.ud_a = 1'b1; bus.cnt_a = 4'd10; bus.div = 3'd2;
    @(negedge clk);
    chk("abort gnt_a", bus.gnt_a, 1'b1);
    bus.req_a = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort mid q", bus.q, 4'b0100);
    chk("abort mid busy", bus.busy, 1'b1);
    #2;
    clear_n = 1'b0;
    #1;
    chk("abort async q", bus.q, 4'b0001);
    chk("abort async busy", bus.busy, 1'b0);
    chk("abort async done", bus.done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort hold done", bus.done, 1'b0);
      chk("abort hold q", bus.q, 4'b0001);
    end
    clear_n = 1'b1;
    @(negedge clk);
    chk("abort after busy", bus.busy, 1'b0);
    chk("abort after done", bus.done, 1'b0);
    chk("abort after q", bus.q, 4'b0001);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
